// File: rtl/sink_line_sched_if.sv
// Control/status bundle between the line scheduler and its axi_sink / video timing / read side.
interface sink_line_sched_if #(
  parameter int unsigned LINE_W = 11
) ();
  logic              frame_start_i;
  logic              line_start_i;
  logic [31:0]       base0_i;
  logic [31:0]       base1_i;
  logic              bvalid_i;
  logic [1:0]        bresp_i;
  logic              aval_o;
  logic [31:0]       addr_o;
  logic              en_o;
  logic [LINE_W-1:0] line_o;
  logic              rd_buf_o;
  logic              frame_done_o;
  logic              overrun_o;
  logic              err_o;

  modport master (
    input  frame_start_i, line_start_i, base0_i, base1_i, bvalid_i, bresp_i,
    output aval_o, addr_o, en_o, line_o, rd_buf_o, frame_done_o, overrun_o, err_o
  );

  modport slave (
    output frame_start_i, line_start_i, base0_i, base1_i, bvalid_i, bresp_i,
    input  aval_o, addr_o, en_o, line_o, rd_buf_o, frame_done_o, overrun_o, err_o
  );
endinterface

// File: rtl/sink_line_sched.sv
// Per-frame line sequencer for one axi_sink: issues line addresses, counts B responses,
// ping-pongs between two frame buffers and flags overruns and write errors.
module sink_line_sched #(
  parameter int unsigned WIDTH  = 24,
  parameter int unsigned SIZE   = 1920,
  parameter int unsigned HEIGHT = 1080
) (
  input  logic              clk_i,
  input  logic              srst_i,
  sink_line_sched_if.master bus
);

  localparam int unsigned NBATCH = (WIDTH * SIZE + 1023) / 1024;
  localparam int unsigned STRIDE = NBATCH * 128;
  localparam int unsigned LINE_W = $clog2(HEIGHT + 1);
  localparam int unsigned CNT_W  = $clog2(NBATCH + 1);
  localparam logic [31:0] STRIDE_32 = 32'(STRIDE);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT,
    ST_RUN
  } state_t;

  state_t            state_q, state_d;
  logic              wbuf_q, wbuf_d;
  logic [31:0]       base0_q, base0_d;
  logic [31:0]       base1_q, base1_d;
  logic [LINE_W-1:0] line_q, line_d;
  logic [CNT_W-1:0]  bcnt_q, bcnt_d;
  logic [31:0]       addr_q, addr_d;
  logic              aval_q, aval_d;
  logic              rd_buf_q, rd_buf_d;
  logic              frame_done_q, frame_done_d;
  logic              overrun_q, overrun_d;
  logic              err_q, err_d;

  logic [LINE_W-1:0] line_inc;
  logic [31:0]       base_sel;
  logic [31:0]       addr_cur;
  logic [31:0]       addr_next;
  logic              commit;
  logic              last_line;

  always_comb begin
    line_inc  = line_q + LINE_W'(1);
    base_sel  = wbuf_q ? base1_q : base0_q;
    addr_cur  = base_sel + 32'(line_q) * STRIDE_32;
    addr_next = base_sel + 32'(line_inc) * STRIDE_32;
    commit    = (state_q == ST_RUN) && bus.bvalid_i && (bcnt_q == CNT_W'(NBATCH - 1));
    last_line = (line_q == LINE_W'(HEIGHT - 1));
  end

  always_comb begin
    state_d      = state_q;
    wbuf_d       = wbuf_q;
    base0_d      = base0_q;
    base1_d      = base1_q;
    line_d       = line_q;
    bcnt_d       = bcnt_q;
    addr_d       = addr_q;
    aval_d       = 1'b0;
    rd_buf_d     = rd_buf_q;
    frame_done_d = 1'b0;
    overrun_d    = overrun_q;
    err_d        = err_q;

    if (bus.bvalid_i && (bus.bresp_i != 2'b00)) begin
      err_d = 1'b1;
    end

    if (bus.frame_start_i) begin
      wbuf_d    = ~rd_buf_q;
      base0_d   = bus.base0_i;
      base1_d   = bus.base1_i;
      line_d    = '0;
      bcnt_d    = '0;
      overrun_d = (state_q == ST_RUN);
      err_d     = 1'b0;
      state_d   = ST_WAIT;
    end else begin
      unique case (state_q)
        ST_IDLE: ;
        ST_WAIT: begin
          if (bus.line_start_i) begin
            aval_d  = 1'b1;
            addr_d  = addr_cur;
            bcnt_d  = '0;
            state_d = ST_RUN;
          end
        end
        ST_RUN: begin
          if (bus.bvalid_i) begin
            bcnt_d = bcnt_q + CNT_W'(1);
          end
          if (commit) begin
            line_d = line_inc;
            bcnt_d = '0;
            if (last_line) begin
              rd_buf_d     = wbuf_q;
              frame_done_d = 1'b1;
              state_d      = ST_IDLE;
            end else if (bus.line_start_i) begin
              // Back-to-back line: the new address already uses the committed line index.
              aval_d  = 1'b1;
              addr_d  = addr_next;
              state_d = ST_RUN;
            end else begin
              state_d = ST_WAIT;
            end
          end else if (bus.line_start_i) begin
            overrun_d = 1'b1;
            line_d    = line_inc;
            bcnt_d    = '0;
            if (last_line) begin
              state_d = ST_IDLE;
            end else begin
              aval_d = 1'b1;
              addr_d = addr_next;
            end
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (srst_i) begin
      state_q      <= ST_IDLE;
      wbuf_q       <= 1'b0;
      base0_q      <= '0;
      base1_q      <= '0;
      line_q       <= '0;
      bcnt_q       <= '0;
      addr_q       <= '0;
      aval_q       <= 1'b0;
      rd_buf_q     <= 1'b1;
      frame_done_q <= 1'b0;
      overrun_q    <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      wbuf_q       <= wbuf_d;
      base0_q      <= base0_d;
      base1_q      <= base1_d;
      line_q       <= line_d;
      bcnt_q       <= bcnt_d;
      addr_q       <= addr_d;
      aval_q       <= aval_d;
      rd_buf_q     <= rd_buf_d;
      frame_done_q <= frame_done_d;
      overrun_q    <= overrun_d;
      err_q        <= err_d;
    end
  end

  assign bus.aval_o       = aval_q;
  assign bus.addr_o       = addr_q;
  assign bus.en_o         = (state_q != ST_IDLE);
  assign bus.line_o       = line_q;
  assign bus.rd_buf_o     = rd_buf_q;
  assign bus.frame_done_o = frame_done_q;
  assign bus.overrun_o    = overrun_q;
  assign bus.err_o        = err_q;

endmodule
